// File: rtl/ifid_fetch_stage.sv
// rtl/ifid_fetch_stage.sv - fetch PC, IF/ID register, load-use hazard detection and branch flush
// One prioritised action per cycle: flush, hold, load-use stall or advance.
module ifid_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             hold_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic             bubble_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_STALL
  } action_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      pc_q;
  logic [31:0]      ifid_pc_q;
  logic [31:0]      ifid_instr_q;
  logic             ifid_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_use;
  action_e    act;

  assign opcode = ifid_instr_q[6:0];
  assign rs1    = ifid_instr_q[19:15];
  assign rs2    = ifid_instr_q[24:20];

  // Only register fields that are actually read count; immediates overlapping rs1/rs2 are ignored.
  always_comb begin
    uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    uses_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    load_use = ifid_valid_q && idex_memread_i && (idex_rd_i != 5'd0) &&
               ((uses_rs1 && (rs1 == idex_rd_i)) || (uses_rs2 && (rs2 == idex_rd_i)));
  end

  always_comb begin
    act = ACT_ADVANCE;
    if (branch_taken_i) begin
      act = ACT_FLUSH;
    end else if (hold_i) begin
      act = ACT_HOLD;
    end else if (load_use) begin
      act = ACT_STALL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= PC_RESET;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          pc_q         <= branch_target_i;
          ifid_pc_q    <= pc_q;
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
          if (flush_cnt_q != CNT_MAX) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
          end
        end
        ACT_HOLD: begin
        end
        ACT_STALL: begin
          if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          pc_q         <= pc_q + PC_STEP;
          ifid_pc_q    <= pc_q;
          ifid_instr_q <= instr_i;
          ifid_valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign bubble_o     = (act == ACT_STALL) && !rst_i;
  assign flush_o      = (act == ACT_FLUSH) && !rst_i;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// tb/tb_ifid_fetch_stage.sv - bench for ifid_fetch_stage
// Directed vector table, reset/saturation sequences, then random traffic against a reference model.
module tb_ifid_fetch_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      instr_i;
  logic             hold_i;
  logic             branch_taken_i;
  logic [31:0]      branch_target_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic [31:0]      pc_o;
  logic [31:0]      ifid_pc_o;
  logic [31:0]      ifid_instr_o;
  logic             ifid_valid_o;
  logic             bubble_o;
  logic             flush_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  ifid_fetch_stage #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .hold_i(hold_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .pc_o(pc_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o),
    .ifid_valid_o(ifid_valid_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction encodings used by the directed vectors
  localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;
  localparam logic [31:0] ADDI_X6_X1_5 = 32'h0050_8313;
  localparam logic [31:0] SW_X5_0_X1   = 32'h0050_A023;
  localparam logic [31:0] LUI_X5       = 32'h0002_82B7;
  localparam logic [31:0] JUNK         = 32'hDEAD_BEEF;

  typedef struct {
    bit          br;
    logic [31:0] tgt;
    bit          hold;
    bit          mr;
    logic [4:0]  rd;
    logic [31:0] ins;
    bit          e_bub;
    bit          e_fl;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic [31:0] e_ins;
    bit          e_v;
    int          e_sc;
    int          e_fc;
  } vec_t;

  function automatic vec_t mk(bit br, logic [31:0] tgt, bit hold, bit mr, logic [4:0] rd,
                              logic [31:0] ins, bit eb, bit ef, logic [31:0] epc,
                              logic [31:0] eifpc, logic [31:0] eins, bit ev, int esc, int efc);
    vec_t v;
    v.br = br; v.tgt = tgt; v.hold = hold; v.mr = mr; v.rd = rd; v.ins = ins;
    v.e_bub = eb; v.e_fl = ef; v.e_pc = epc; v.e_ifpc = eifpc; v.e_ins = eins;
    v.e_v = ev; v.e_sc = esc; v.e_fc = efc;
    return v;
  endfunction

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ins;
  bit          m_v;
  int          m_sc, m_fc;

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ins = NOP; m_v = 0; m_sc = 0; m_fc = 0;
  endtask

  function automatic bit model_lu();
    logic [6:0] op;
    bit r1, r2;
    op = m_ins[6:0];
    r1 = !(op inside {7'h37, 7'h17, 7'h6F});
    r2 = op inside {7'h33, 7'h23, 7'h63};
    return m_v && idex_memread_i && (idex_rd_i != 0) &&
           ((r1 && m_ins[19:15] == idex_rd_i) || (r2 && m_ins[24:20] == idex_rd_i));
  endfunction

  task automatic model_check(input string tag);
    bit lu;
    lu = model_lu();
    chk({tag, " pc"}, pc_o, m_pc);
    chk({tag, " ifid_pc"}, ifid_pc_o, m_ifpc);
    chk({tag, " ifid_instr"}, ifid_instr_o, m_ins);
    chk({tag, " valid"}, 32'(ifid_valid_o), 32'(m_v));
    chk({tag, " bubble"}, 32'(bubble_o), 32'(!rst_i && lu && !branch_taken_i && !hold_i));
    chk({tag, " flush"}, 32'(flush_o), 32'(branch_taken_i && !rst_i));
    chk({tag, " stall_cnt"}, 32'(stall_cnt_o), 32'(m_sc));
    chk({tag, " flush_cnt"}, 32'(flush_cnt_o), 32'(m_fc));
  endtask

  task automatic model_step();
    if (rst_i) begin
      model_reset();
    end else if (branch_taken_i) begin
      m_ifpc = m_pc; m_ins = NOP; m_v = 0; m_pc = branch_target_i;
      m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    end else if (hold_i) begin
    end else if (model_lu()) begin
      m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    end else begin
      m_ifpc = m_pc; m_ins = instr_i; m_v = 1; m_pc = m_pc + 32'd4;
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked at the falling edge.
  task automatic run_cycle(input string tag);
    if (rst_i) model_reset();
    @(negedge clk_i);
    model_check(tag);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(bit br, logic [31:0] tgt, bit hold, bit mr, logic [4:0] rd, logic [31:0] ins);
    branch_taken_i = br; branch_target_i = tgt; hold_i = hold;
    idex_memread_i = mr; idex_rd_i = rd; instr_i = ins;
  endtask

  vec_t tbl[17];
  logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 32'h1111_0001, 0, 0, 32'h04, 32'h00, 32'h1111_0001, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 32'h2222_0002, 0, 0, 32'h08, 32'h04, 32'h2222_0002, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h3333_0003, 0, 0, 32'h0C, 32'h08, 32'h3333_0003, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 32'h4444_0004, 0, 0, 32'h10, 32'h0C, 32'h4444_0004, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, ADD_X6_X5_X7, 0, 0, 32'h14, 32'h10, ADD_X6_X5_X7, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 5, JUNK,         1, 0, 32'h14, 32'h10, ADD_X6_X5_X7, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 5, ADDI_X6_X1_5, 0, 0, 32'h18, 32'h14, ADDI_X6_X1_5, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 5, SW_X5_0_X1,   0, 0, 32'h1C, 32'h18, SW_X5_0_X1,   1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 1, 5, JUNK,         1, 0, 32'h1C, 32'h18, SW_X5_0_X1,   1, 2, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0, LUI_X5,       0, 0, 32'h20, 32'h1C, LUI_X5,       1, 2, 0);
    tbl[10] = mk(0, 0, 0, 1, 5, ADD_X6_X5_X7, 0, 0, 32'h24, 32'h20, ADD_X6_X5_X7, 1, 2, 0);
    tbl[11] = mk(1, 32'h100, 0, 1, 5, JUNK,   0, 1, 32'h100, 32'h24, NOP,         0, 2, 1);
    tbl[12] = mk(0, 0, 0, 1, 5, ADD_X6_X5_X7, 0, 0, 32'h104, 32'h100, ADD_X6_X5_X7, 1, 2, 1);
    tbl[13] = mk(0, 0, 1, 1, 5, JUNK,         0, 0, 32'h104, 32'h100, ADD_X6_X5_X7, 1, 2, 1);
    tbl[14] = mk(1, 32'hFFFF_FFFC, 1, 1, 5, JUNK, 0, 1, 32'hFFFF_FFFC, 32'h104, NOP, 0, 2, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 32'h5555_0005, 0, 0, 32'h00, 32'hFFFF_FFFC, 32'h5555_0005, 1, 2, 2);
    tbl[16] = mk(0, 0, 0, 0, 0, 32'h6666_0006, 0, 0, 32'h04, 32'h00, 32'h6666_0006, 1, 2, 2);

    // Power-on reset with a taken branch pending: flush_o must stay low
    rst_i = 1'b1;
    set_in(1, 32'h100, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("por pc", pc_o, 32'h0);
    chk("por ifid_pc", ifid_pc_o, 32'h0);
    chk("por ifid_instr", ifid_instr_o, NOP);
    chk("por valid", 32'(ifid_valid_o), 32'h0);
    chk("por flush", 32'(flush_o), 32'h0);
    chk("por bubble", 32'(bubble_o), 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].br, tbl[i].tgt, tbl[i].hold, tbl[i].mr, tbl[i].rd, tbl[i].ins);
      @(negedge clk_i);
      chk($sformatf("vec%0d bubble", i), 32'(bubble_o), 32'(tbl[i].e_bub));
      chk($sformatf("vec%0d flush", i), 32'(flush_o), 32'(tbl[i].e_fl));
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d pc", i), pc_o, tbl[i].e_pc);
      chk($sformatf("vec%0d ifid_pc", i), ifid_pc_o, tbl[i].e_ifpc);
      chk($sformatf("vec%0d ifid_instr", i), ifid_instr_o, tbl[i].e_ins);
      chk($sformatf("vec%0d valid", i), 32'(ifid_valid_o), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt_o), 32'(tbl[i].e_sc));
      chk($sformatf("vec%0d flush_cnt", i), 32'(flush_cnt_o), 32'(tbl[i].e_fc));
    end

    // Mid-run asynchronous reset: state clears before any clock edge
    set_in(1, 32'h200, 0, 1, 5, ADD_X6_X5_X7);
    rst_i = 1'b1;
    #1;
    chk("async pc", pc_o, 32'h0);
    chk("async ifid_instr", ifid_instr_o, NOP);
    chk("async valid", 32'(ifid_valid_o), 32'h0);
    chk("async stall_cnt", 32'(stall_cnt_o), 32'h0);
    chk("async flush_cnt", 32'(flush_cnt_o), 32'h0);
    chk("async flush", 32'(flush_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();

    // Counter saturation: continuous load-use, then continuous flushes
    set_in(0, 0, 0, 0, 0, ADD_X6_X5_X7);
    run_cycle("sat_fill");
    set_in(0, 0, 0, 1, 5, JUNK);
    for (int i = 0; i < CMAX + 4; i++) run_cycle("sat_stall");
    set_in(0, 0, 1, 1, 5, JUNK);
    run_cycle("sat_hold");
    for (int i = 0; i < CMAX + 4; i++) begin
      set_in(1, 32'h40 + 32'(i * 4), 0, 1, 5, JUNK);
      run_cycle("sat_flush");
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[24:20] = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[6:0]   = ops[$urandom_range(0, 9)];
      rst_i = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), w);
      run_cycle("rand");
    end
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
